bottle_flip_game: RTL and testbench

Game-state core of the bottle-flip game, clocked by the render clock (one edge per frame).
- Holds three landing squares and the player.
- Executes a jump of a requested distance, judges the landing, and updates a 4-digit BCD score.
- Pulses `perfect` on a centre hit, then scrolls the playfield.
- Its outputs feed the renderer, the 7-segment driver and the LED effect block.

---
 rtl/bottle_flip_game.sv | 244 ++++++++++++++++++++++++
 tb/tb_bottle_flip_game.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bottle_flip_game.sv
`default_nettype none
// ============================================================================
// Module   : bottle_flip_game
// Purpose  : Game-state core of the bottle-flip game. Holds three landing
//            squares and the player, runs a jump of the requested distance,
//            judges the landing, keeps a saturating 4-digit BCD score and
//            scrolls the playfield after every successful landing.
// Ports    : clk        - render clock, one rising edge per frame
//            restart    - synchronous active-high reset
//            jump_dist  - requested jump distance, 0 = no request
//            square1    - square the player stands on {center, half_width}
//            square2    - target square               {center, half_width}
//            square3    - next square                 {center, half_width}
//            player     - {x, height}
//            out_score  - four BCD digits, [15:12] = thousands
//            perfect    - one-cycle pulse on a centre hit
// Options  : PERFECT_BONUS_EN - when defined a perfect landing scores 2
//            instead of 1.
// Revision : 1.0 - initial release
// ============================================================================
module bottle_flip_game #(
    parameter int SQ_WIDTH     = 12,
    parameter int PLAYER_WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    restart,
    input  logic [7:0]              jump_dist,
    output logic [SQ_WIDTH-1:0]     square1,
    output logic [SQ_WIDTH-1:0]     square2,
    output logic [SQ_WIDTH-1:0]     square3,
    output logic [PLAYER_WIDTH-1:0] player,
    output logic [15:0]             out_score,
    output logic                    perfect
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_JUMP   = 3'd1;
    localparam logic [2:0] c_LAND   = 3'd2;
    localparam logic [2:0] c_SCROLL = 3'd3;
    localparam logic [2:0] c_OVER   = 3'd4;

    localparam logic [SQ_WIDTH-1:0] c_SQ1_INIT = {8'd8,  4'd3};
    localparam logic [SQ_WIDTH-1:0] c_SQ2_INIT = {8'd23, 4'd3};
    localparam logic [SQ_WIDTH-1:0] c_SQ3_INIT = {8'd40, 4'd2};
    localparam logic [7:0]          c_HOME_X   = 8'd8;
    localparam logic [7:0]          c_LFSR_INIT = 8'hA5;

    // Registered state
    logic [2:0]          r_state;
    logic [SQ_WIDTH-1:0] r_sq1, r_sq2, r_sq3;
    logic [7:0]          r_px;
    logic [5:0]          r_ph;
    logic [15:0]         r_score;
    logic                r_perfect;
    logic [7:0]          r_lfsr;
    logic [7:0]          r_step;
    logic [7:0]          r_dist;
    logic [7:0]          r_scroll;

    // Next-state values
    logic [2:0]          w_state;
    logic [SQ_WIDTH-1:0] w_sq1, w_sq2, w_sq3;
    logic [7:0]          w_px;
    logic [5:0]          w_ph;
    logic [15:0]         w_score;
    logic                w_perfect;
    logic [7:0]          w_step;
    logic [7:0]          w_dist;
    logic [7:0]          w_scroll;

    // Helpers
    logic [7:0]  w_step_inc;
    logic [7:0]  w_rem;
    logic [7:0]  w_hmin;
    logic [5:0]  w_height;
    logic [7:0]  w_c2;
    logic [7:0]  w_c3;
    logic [7:0]  w_offset;
    logic        w_hit;
    logic        w_center_hit;
    logic [15:0] w_score_one;
    logic [15:0] w_score_add;
    logic [7:0]  w_k;
    logic        w_lfsr_fb;

    // Saturating BCD increment; 9999 is the ceiling.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (res[4*i +: 4] == 4'd9) begin
                        res[4*i +: 4] = 4'd0;
                    end else begin
                        res[4*i +: 4] = res[4*i +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
        return res;
    endfunction

    // Move a square left by k units, keeping its half width.
    function automatic logic [SQ_WIDTH-1:0] sq_shift(input logic [SQ_WIDTH-1:0] sq,
                                                     input logic [7:0] k);
        return {sq[SQ_WIDTH-1 -: 8] - k, sq[3:0]};
    endfunction

    // Jump arc: height is the distance to the nearer end of the jump.
    assign w_step_inc = r_step + 8'd1;
    assign w_rem      = r_dist - w_step_inc;
    assign w_hmin     = (w_step_inc < w_rem) ? w_step_inc : w_rem;
    assign w_height   = (w_hmin > 8'd63) ? 6'd63 : w_hmin[5:0];

    // Landing judgement against the target square.
    assign w_c2         = r_sq2[SQ_WIDTH-1 -: 8];
    assign w_c3         = r_sq3[SQ_WIDTH-1 -: 8];
    assign w_offset     = (r_px >= w_c2) ? (r_px - w_c2) : (w_c2 - r_px);
    assign w_hit        = (w_offset <= {4'd0, r_sq2[3:0]});
    assign w_center_hit = (w_offset == 8'd0);
    assign w_score_one  = bcd_inc(r_score);

`ifdef PERFECT_BONUS_EN
    assign w_score_add = w_center_hit ? bcd_inc(w_score_one) : w_score_one;
`else
    assign w_score_add = w_score_one;
`endif

    // Scroll at most two units per frame.
    assign w_k = (r_scroll >= 8'd2) ? 8'd2 : r_scroll;

    // x^8 + x^6 + x^5 + x^4 + 1
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_comb begin
        w_state   = r_state;
        w_sq1     = r_sq1;
        w_sq2     = r_sq2;
        w_sq3     = r_sq3;
        w_px      = r_px;
        w_ph      = r_ph;
        w_score   = r_score;
        w_perfect = 1'b0;
        w_step    = r_step;
        w_dist    = r_dist;
        w_scroll  = r_scroll;

        case (r_state)
            c_IDLE: begin
                if (jump_dist != 8'd0) begin
                    w_dist  = jump_dist;
                    w_px    = c_HOME_X;
                    w_ph    = 6'd0;
                    w_step  = 8'd0;
                    w_state = c_JUMP;
                end
            end
            c_JUMP: begin
                w_step = w_step_inc;
                w_px   = (r_px == 8'hFF) ? r_px : (r_px + 8'd1);
                w_ph   = w_height;
                if (w_step_inc == r_dist) begin
                    w_state = c_LAND;
                end
            end
            c_LAND: begin
                if (w_hit) begin
                    w_score   = w_score_add;
                    w_perfect = w_center_hit;
                    w_scroll  = w_c2 - c_HOME_X;
                    w_state   = c_SCROLL;
                end else begin
                    w_state = c_OVER;
                end
            end
            c_SCROLL: begin
                if (r_scroll == 8'd0) begin
                    // Target becomes the home square; a fresh square is
                    // spawned at a pseudo-random gap beyond the new target.
                    w_sq1   = r_sq2;
                    w_sq2   = r_sq3;
                    w_sq3   = {w_c3 + 8'd12 + {4'd0, r_lfsr[3:0]},
                               4'd2 + {2'd0, r_lfsr[5:4]}};
                    w_state = c_IDLE;
                end else begin
                    w_sq1    = sq_shift(r_sq1, w_k);
                    w_sq2    = sq_shift(r_sq2, w_k);
                    w_sq3    = sq_shift(r_sq3, w_k);
                    w_px     = r_px - w_k;
                    w_scroll = r_scroll - w_k;
                end
            end
            c_OVER: begin
                w_ph = 6'd0;
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            r_state   <= c_IDLE;
            r_sq1     <= c_SQ1_INIT;
            r_sq2     <= c_SQ2_INIT;
            r_sq3     <= c_SQ3_INIT;
            r_px      <= c_HOME_X;
            r_ph      <= 6'd0;
            r_score   <= 16'h0000;
            r_perfect <= 1'b0;
            r_lfsr    <= c_LFSR_INIT;
            r_step    <= 8'd0;
            r_dist    <= 8'd0;
            r_scroll  <= 8'd0;
        end else begin
            r_state   <= w_state;
            r_sq1     <= w_sq1;
            r_sq2     <= w_sq2;
            r_sq3     <= w_sq3;
            r_px      <= w_px;
            r_ph      <= w_ph;
            r_score   <= w_score;
            r_perfect <= w_perfect;
            r_lfsr    <= {r_lfsr[6:0], w_lfsr_fb};
            r_step    <= w_step;
            r_dist    <= w_dist;
            r_scroll  <= w_scroll;
        end
    end

    assign square1   = r_sq1;
    assign square2   = r_sq2;
    assign square3   = r_sq3;
    assign player    = {r_px, r_ph};
    assign out_score = r_score;
    assign perfect   = r_perfect;

endmodule
`default_nettype wire

// File: tb/tb_bottle_flip_game.sv
`default_nettype none
// ============================================================================
// Module   : tb_bottle_flip_game
// Purpose  : Self-checking bench for bottle_flip_game. A table of jumps with
//            hand-derived landing results is replayed from the reset layout;
//            hand-written sequences cover chained jumps, mid-jump and
//            mid-scroll restart and BCD carry/saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bottle_flip_game;

    logic        clk = 1'b0;
    logic        restart;
    logic [7:0]  jump_dist;
    logic [11:0] square1, square2, square3;
    logic [13:0] player;
    logic [15:0] out_score;
    logic        perfect;

    always #5 clk = ~clk;

    bottle_flip_game #(
        .SQ_WIDTH     (12),
        .PLAYER_WIDTH (14)
    ) dut (
        .clk       (clk),
        .restart   (restart),
        .jump_dist (jump_dist),
        .square1   (square1),
        .square2   (square2),
        .square3   (square3),
        .player    (player),
        .out_score (out_score),
        .perfect   (perfect)
    );

`ifdef PERFECT_BONUS_EN
    localparam int BONUS = 2;
`else
    localparam int BONUS = 1;
`endif

    typedef struct packed {
        logic [11:0] sq1;
        logic [11:0] sq2;
        logic [11:0] sq3;
        logic [13:0] pl;
        logic [15:0] sc;
        logic        pf;
    } exp_t;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] x_land;
        logic       hit;
        logic       pf;
        logic       stray;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Expected outputs after the next edge
    logic [11:0] e_sq1, e_sq2, e_sq3;
    logic [13:0] e_pl;
    logic [15:0] e_sc;
    logic        e_pf;

    // Reference LFSR, x^8 + x^6 + x^5 + x^4 + 1
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (restart) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic init_exp();
        e_sq1 = {8'd8,  4'd3};
        e_sq2 = {8'd23, 4'd3};
        e_sq3 = {8'd40, 4'd2};
        e_pl  = {8'd8,  6'd0};
        e_sc  = 16'h0000;
        e_pf  = 1'b0;
    endtask

    // One frame: drive inputs, queue expectation, compare after the edge.
    task automatic cyc(input logic rs, input logic [7:0] jd, input string nm);
        exp_t e;
        restart   = rs;
        jump_dist = jd;
        e.sq1 = e_sq1; e.sq2 = e_sq2; e.sq3 = e_sq3;
        e.pl  = e_pl;  e.sc  = e_sc;  e.pf  = e_pf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({nm, ".square1"}, {4'd0, square1}, {4'd0, e.sq1});
        chk({nm, ".square2"}, {4'd0, square2}, {4'd0, e.sq2});
        chk({nm, ".square3"}, {4'd0, square3}, {4'd0, e.sq3});
        chk({nm, ".player"},  {2'd0, player},  {2'd0, e.pl});
        chk({nm, ".score"},   out_score,       e.sc);
        chk({nm, ".perfect"}, {15'd0, perfect}, {15'd0, e.pf});
    endtask

    function automatic logic [15:0] bcd_add(input logic [15:0] v, input int n);
        int d;
        d = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]) + n;
        if (d > 9999) d = 9999;
        return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
    endfunction

    // Jump from IDLE; abort_at > 0 asserts restart on that scroll frame.
    task automatic do_jump(input vec_t v, input int abort_at);
        int c2, r, k, x, h, st;
        c2   = int'(e_sq2[11:4]);
        e_pl = {8'd8, 6'd0};
        e_pf = 1'b0;
        cyc(1'b0, v.d, "launch");
        for (int s = 1; s <= int'(v.d); s++) begin
            if (s == int'(v.d)) begin
                e_pl = {v.x_land, 6'd0};
            end else begin
                x = 8 + s;
                if (x > 255) x = 255;
                h = s;
                if (int'(v.d) - s < h) h = int'(v.d) - s;
                if (h > 63) h = 63;
                e_pl = {8'(x), 6'(h)};
            end
            cyc(1'b0, (v.stray && s == 2) ? 8'd19 : 8'd0, "flight");
        end
        if (v.hit) e_sc = bcd_add(e_sc, v.pf ? BONUS : 1);
        e_pf = v.pf;
        cyc(1'b0, 8'd0, "land");
        e_pf = 1'b0;
        if (v.hit) begin
            r  = c2 - 8;
            st = 0;
            while (r > 0) begin
                st++;
                if (st == abort_at) begin
                    init_exp();
                    cyc(1'b1, 8'd0, "scroll_restart");
                    return;
                end
                k = (r >= 2) ? 2 : r;
                e_sq1[11:4] = e_sq1[11:4] - 8'(k);
                e_sq2[11:4] = e_sq2[11:4] - 8'(k);
                e_sq3[11:4] = e_sq3[11:4] - 8'(k);
                e_pl[13:6]  = e_pl[13:6]  - 8'(k);
                cyc(1'b0, (st == 1) ? 8'd15 : 8'd0, "scroll");
                r -= k;
            end
            e_sq1 = e_sq2;
            e_sq2 = e_sq3;
            e_sq3 = {e_sq2[11:4] + 8'd12 + {4'd0, m_lfsr[3:0]}, 4'd2 + {2'd0, m_lfsr[5:4]}};
            cyc(1'b0, 8'd0, "rotate");
            cyc(1'b0, 8'd0, "settle");
        end else begin
            for (int i = 0; i < 6; i++) cyc(1'b0, (i == 2) ? 8'd15 : 8'd0, "over");
        end
    endtask

    vec_t vecs[10];
    vec_t v13, v15, v17, v25;

    initial begin
        // d, x_land, hit, perfect, stray request during flight
        vecs[0] = '{8'd13,  8'd21,  1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'd15,  8'd23,  1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'd25,  8'd33,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'd12,  8'd20,  1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'd11,  8'd19,  1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'd18,  8'd26,  1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'd19,  8'd27,  1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'd1,   8'd9,   1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'd200, 8'd208, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'd255, 8'd255, 1'b0, 1'b0, 1'b0};
        v13 = '{8'd13, 8'd21, 1'b1, 1'b0, 1'b0};
        v15 = '{8'd15, 8'd23, 1'b1, 1'b1, 1'b0};
        v17 = '{8'd17, 8'd25, 1'b1, 1'b1, 1'b0};
        v25 = '{8'd25, 8'd33, 1'b0, 1'b0, 1'b0};

        restart   = 1'b1;
        jump_dist = 8'd0;
        init_exp();
        cyc(1'b1, 8'd0, "reset");
        cyc(1'b1, 8'd0, "reset");
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'd0, "idle");

        for (int i = 0; i < 10; i++) begin
            init_exp();
            cyc(1'b1, 8'd0, "restart");
            do_jump(vecs[i], 0);
        end

        // Miss, then restart and score again
        init_exp();
        cyc(1'b1, 8'd0, "restart");
        do_jump(v25, 0);
        init_exp();
        cyc(1'b1, 8'd0, "restart_after_over");
        do_jump(v15, 0);

        // Chained jump on the rotated layout: new target centre is 25
        init_exp();
        cyc(1'b1, 8'd0, "restart");
        do_jump(v13, 0);
        do_jump(v17, 0);

        // Restart mid-jump
        init_exp();
        cyc(1'b1, 8'd0, "restart");
        e_pl = {8'd8, 6'd0};
        cyc(1'b0, 8'd30, "launch30");
        for (int s = 1; s <= 5; s++) begin
            e_pl = {8'(8 + s), 6'(s)};
            cyc(1'b0, 8'd0, "flight30");
        end
        init_exp();
        cyc(1'b1, 8'd0, "jump_restart");
        cyc(1'b0, 8'd0, "idle_after_restart");

        // Restart mid-scroll
        init_exp();
        cyc(1'b1, 8'd0, "restart");
        do_jump(v13, 4);
        cyc(1'b0, 8'd0, "idle_after_scroll_restart");

        // BCD carry 0009 -> 0010
        init_exp();
        cyc(1'b1, 8'd0, "restart");
        force dut.r_score = 16'h0009;
        e_sc = 16'h0009;
        cyc(1'b0, 8'd0, "preload9");
        release dut.r_score;
        do_jump(v13, 0);

        // Saturation at 9999
        init_exp();
        cyc(1'b1, 8'd0, "restart");
        force dut.r_score = 16'h9999;
        e_sc = 16'h9999;
        cyc(1'b0, 8'd0, "preload9999");
        release dut.r_score;
        do_jump(v13, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
